// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with first-word-fall-through read data, occupancy count,
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and synchronous flush.
// Pointers carry one extra wrap bit so full and empty are distinguishable without a counter.
module fifo_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic                     re,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     flush,
  input  logic                     clr_err,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW:0] AfThresh = CW'(AF_THRESH);
  localparam logic [AW:0] AeThresh = CW'(AE_THRESH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              full_w, empty_w;
  logic              push_ok, pop_ok;
  logic [AW:0]       count_w;

  // Status is derived purely from registered pointers, so no input reaches an output.
  always_comb begin
    count_w = wr_ptr_q - rd_ptr_q;
    full_w  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty_w = (wr_ptr_q == rd_ptr_q);
  end

  // Next-state for pointers and sticky error flags; flush dominates push/pop and suppresses errors.
  always_comb begin
    push_ok     = we & ~full_w & ~flush;
    pop_ok      = re & ~empty_w & ~flush;
    wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
    // A new error event wins over a coincident clear.
    overflow_d  = (we & full_w & ~flush) | (overflow_q & ~clr_err);
    underflow_d = (re & empty_w & ~flush) | (underflow_q & ~clr_err);
  end

  // Pointer and error-flag state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

  // Output drive: head entry falls through, flags come from the registered pointers.
  always_comb begin
    rdata        = mem_q[rd_ptr_q[AW-1:0]];
    full         = full_w;
    empty        = empty_w;
    count        = count_w;
    almost_full  = (count_w >= AfThresh);
    almost_empty = (count_w <= AeThresh);
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          clk;
  logic          rst;
  logic          we, re, flush, clr_err;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]    count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic          m_ovf, m_unf;

  fifo_param #(
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .AF_THRESH(AF),
    .AE_THRESH(AE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .we          (we),
    .re          (re),
    .wdata       (wdata),
    .flush       (flush),
    .clr_err     (clr_err),
    .rdata       (rdata),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: evaluates the FIFO rules on the pre-edge model state.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (flush) begin
      mq.delete();
      if (clr_err) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
    end else begin
      bit was_full, was_empty;
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      if (clr_err) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (we && was_full) m_ovf = 1'b1;
      if (re && was_empty) m_unf = 1'b1;
      if (re && !was_empty) void'(mq.pop_front());
      if (we && !was_full) mq.push_back(wdata);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("m_count", 32'(count), 32'(mq.size()));
    chk("m_empty", 32'(empty), 32'(mq.size() == 0));
    chk("m_full", 32'(full), 32'(mq.size() == DEPTH));
    chk("m_afull", 32'(almost_full), 32'(mq.size() >= AF));
    chk("m_aempty", 32'(almost_empty), 32'(mq.size() <= AE));
    chk("m_ovf", 32'(overflow), 32'(m_ovf));
    chk("m_unf", 32'(underflow), 32'(m_unf));
    if (mq.size() != 0) chk("m_rdata", 32'(rdata), 32'(mq[0]));
  end

  // Apply one cycle of inputs; returns 1 time unit after the edge.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic f,
                     input logic c);
    we      = w;
    re      = r;
    wdata   = d;
    flush   = f;
    clr_err = c;
    @(posedge clk);
    #1;
    we      = 1'b0;
    re      = 1'b0;
    flush   = 1'b0;
    clr_err = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 0; re = 0; wdata = '0; flush = 0; clr_err = 0;
    #1;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_aempty", 32'(almost_empty), 1);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_unf", 32'(underflow), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Fill
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 8'(8'h61 + i), 0, 0);
      if (i == 12) chk("fill_af13", 32'(almost_full), 0);
      if (i == 13) chk("fill_af14", 32'(almost_full), 1);
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 16);
    // Overflow
    cyc(1, 0, 8'hAA, 0, 0);
    chk("ovf_count", 32'(count), 16);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_head", 32'(rdata), 32'h61);
    // Drain
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", 32'(rdata), 32'(8'h61 + i));
      cyc(0, 1, 0, 0, 0);
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_count", 32'(count), 0);
    cyc(0, 1, 0, 0, 0);
    chk("unf_flag", 32'(underflow), 1);
    cyc(0, 0, 0, 0, 1);
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_unf", 32'(underflow), 0);
    cyc(0, 1, 0, 0, 1);
    chk("set_wins", 32'(underflow), 1);
    cyc(0, 0, 0, 0, 1);

    // Simultaneous push/pop
    cyc(1, 0, 8'hAA, 0, 0);
    for (int i = 0; i < 16; i++) begin
      chk("sim_data", 32'(rdata), (i == 0) ? 32'hAA : 32'(i - 1));
      cyc(1, 1, 8'(i), 0, 0);
      chk("sim_count", 32'(count), 1);
    end
    chk("sim_head", 32'(rdata), 32'h0F);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(1, 0, 8'(i), 0, 0);
    cyc(1, 1, 8'h77, 0, 0);
    chk("wr_full_count", 32'(count), 15);
    chk("wr_full_ovf", 32'(overflow), 1);
    for (int i = 0; i < 15; i++) cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 8'h99, 0, 0);
    chk("wr_empty_count", 32'(count), 1);
    chk("wr_empty_unf", 32'(underflow), 1);
    chk("wr_empty_head", 32'(rdata), 32'h99);
    cyc(0, 1, 0, 0, 1);

    // Wrap-around
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) cyc(1, 0, 8'(k * 16 + i), 0, 0);
      for (int i = 0; i < 10; i++) begin
        chk("wrap_data", 32'(rdata), 32'(k * 16 + i));
        cyc(0, 1, 0, 0, 0);
      end
    end

    // Flush
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h20 + i), 0, 0);
    cyc(1, 0, 8'h55, 1, 0);
    chk("flush_empty", 32'(empty), 1);
    chk("flush_count", 32'(count), 0);
    chk("flush_ovf", 32'(overflow), 0);
    chk("flush_unf", 32'(underflow), 0);
    cyc(1, 0, 8'h33, 0, 0);
    chk("flush_next", 32'(rdata), 32'h33);
    chk("flush_next_cnt", 32'(count), 1);
    cyc(0, 1, 0, 0, 0);

    // Asynchronous reset between edges
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'(8'h40 + i), 0, 0);
    cyc(1, 0, 8'hEE, 0, 0);
    for (int i = 0; i < 13; i++) cyc(1, 0, 8'h00, 0, 0);
    cyc(1, 0, 8'h01, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_empty", 32'(empty), 1);
    chk("arst_count", 32'(count), 0);
    chk("arst_full", 32'(full), 0);
    chk("arst_ovf", 32'(overflow), 0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(1, 0, 8'h11, 0, 0);
    chk("arst_push", 32'(rdata), 32'h11);
    cyc(0, 1, 0, 0, 0);
    chk("arst_pop_empty", 32'(empty), 1);

    // Random traffic
    for (int n = 0; n < 256; n++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
          ($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0));
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
